// File: rtl/ff_pkg.sv
// Shared GF(2^255-19) field definitions for the ECC datapath (multiplier and subtractor).
package ff_pkg;

  localparam int unsigned W = 255;
  // 2^255 - 19: all ones above the low byte 0xED
  localparam logic [W-1:0] P = {{(W-8){1'b1}}, 8'hED};

  typedef logic [W-1:0] fe_t;
  typedef logic [W:0]   wide_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  // Valid only for x < 2P, which holds for every caller.
  function automatic fe_t reduce_once(input wide_t x);
    wide_t pw;
    pw = {1'b0, P};
    if (x >= pw) begin
      reduce_once = fe_t'(x - pw);
    end else begin
      reduce_once = fe_t'(x);
    end
  endfunction

endpackage

// File: rtl/ffm_step.sv
// One MSB-first interleaved multiply step: acc_next = (2*acc + bit*a_r) mod P.
module ffm_step
  import ff_pkg::*;
(
  input  logic [W-1:0] acc,
  input  logic [W-1:0] a_r,
  input  logic         b_bit,
  output logic [W-1:0] acc_next
);

  fe_t   dbl;
  wide_t sum;

  always_comb begin
    dbl = reduce_once({acc, 1'b0});
    sum = {1'b0, dbl};
    if (b_bit) begin
      sum = {1'b0, dbl} + {1'b0, a_r};
    end
    acc_next = reduce_once(sum);
  end

endmodule

// File: rtl/ffm_serial.sv
// Bit-serial GF(2^255-19) multiplier: result = a*b mod P after 255 RUN cycles.
module ffm_serial
  import ff_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [254:0] a,
  input  logic [254:0] b,
  output logic [254:0] result,
  output logic         valid,
  output logic         busy
);

  state_e     state_q, state_d;
  fe_t        acc_q, acc_d;
  fe_t        a_r_q, a_r_d;
  fe_t        b_r_q, b_r_d;
  logic [7:0] idx_q, idx_d;
  fe_t        result_q, result_d;
  logic       valid_q, valid_d;
  fe_t        step_out;

  ffm_step u_step (
    .acc      (acc_q),
    .a_r      (a_r_q),
    .b_bit    (b_r_q[idx_q]),
    .acc_next (step_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      a_r_q    <= '0;
      b_r_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      a_r_q    <= a_r_d;
      b_r_q    <= b_r_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (idx_q == 8'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d    = acc_q;
    a_r_d    = a_r_q;
    b_r_d    = b_r_q;
    idx_d    = idx_q;
    result_d = result_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // a < 2^255 < 2P, so one conditional subtraction fully reduces it
          a_r_d = reduce_once({1'b0, a});
          b_r_d = b;
          acc_d = '0;
          idx_d = 8'd254;
        end
      end
      RUN: begin
        acc_d = step_out;
        idx_d = idx_q - 8'd1;
        if (idx_q == 8'd0) begin
          result_d = step_out;
          valid_d  = 1'b1;
          idx_d    = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    result = result_q;
    valid  = valid_q;
    busy   = (state_q == RUN);
  end

endmodule

// File: tb/tb_ffm_serial.sv
// Scoreboard bench for ffm_serial against a plain a*b % P reference.
module tb_ffm_serial;

  localparam logic [254:0] P_TB = 255'((256'd1 << 255) - 256'd19);

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [254:0] a;
  logic [254:0] b;
  logic [254:0] result;
  logic         valid;
  logic         busy;

  always #5 clk = ~clk;

  ffm_serial dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .result (result),
    .valid  (valid),
    .busy   (busy)
  );

  typedef struct {
    logic [254:0] res;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           m_cnt = 0;
  logic [254:0] m_cur = '0;
  logic [254:0] m_last = '0;
  bit           chk_en = 1'b0;

  function automatic logic [254:0] ref_mul(input logic [254:0] x, input logic [254:0] y);
    logic [509:0] prod;
    logic [509:0] md;
    md   = {255'd0, P_TB};
    prod = {255'd0, x} * {255'd0, y};
    return 255'(prod % md);
  endfunction

  function automatic logic [254:0] rnd255();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v[254:0];
  endfunction

  // Reference: accept when idle, complete 255 edges later, rst clears everything
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_cnt  = 0;
      sb.delete();
      m_last = '0;
      chk_en = 1'b1;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_cur = ref_mul(a, b);
        sb.push_back('{res: m_cur, due: cyc + 255});
        m_cnt = 255;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) m_last = m_cur;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (busy !== (m_cnt != 0)) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, (m_cnt != 0));
      end
      if (valid === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL spurious_valid cyc=%0d got result=%h want no valid", cyc, result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (result !== e.res) begin
            bad++;
            $display("FAIL result cyc=%0d got=%h want=%h", cyc, result, e.res);
          end
          total++;
          if (cyc != e.due) begin
            bad++;
            $display("FAIL latency got cyc=%0d want cyc=%0d", cyc, e.due);
          end
        end
      end else begin
        total++;
        if (valid !== 1'b0) begin
          bad++;
          $display("FAIL valid_level cyc=%0d got=%b want=0", cyc, valid);
        end
        total++;
        if (result !== m_last) begin
          bad++;
          $display("FAIL result_hold cyc=%0d got=%h want=%h", cyc, result, m_last);
        end
        if (sb.size() != 0 && sb[0].due <= cyc) begin
          bad++;
          $display("FAIL missing_valid cyc=%0d got no valid want valid at cyc=%0d", cyc, sb[0].due);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic op(input logic [254:0] x, input logic [254:0] y, input int gap);
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = rnd255();
    b = rnd255();
    repeat (256 + gap) @(negedge clk);
  endtask

  initial begin
    logic [254:0] pm1;
    logic [254:0] p254;
    logic [254:0] ones;
    int           n;
    pm1   = P_TB - 255'd1;
    p254  = 255'd1 << 254;
    ones  = '1;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    op(255'd3, 255'd2, 0);
    op(pm1, pm1, 1);
    op(p254, 255'd2, 0);
    op(ones, 255'd2, 2);
    op(255'd0, ones, 0);

    // second start during RUN is ignored
    a = 255'd5; b = 255'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    a = 255'd9; b = 255'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (170) @(negedge clk);

    // reset mid-run aborts without a valid pulse
    a = 255'd5; b = 255'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    op(255'd4, 255'd4, 0);

    // back-to-back with start held high
    a = 255'd2; b = 255'd3; start = 1'b1;
    n = 0;
    @(negedge clk);
    while (valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL b2b_timeout got no valid in %0d cycles want valid", n);
    end
    a = 255'd10; b = 255'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (262) @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      logic [254:0] x;
      logic [254:0] y;
      x = rnd255();
      y = rnd255();
      if (k == 1) x = ones - 255'(k);
      if (k == 2) y = pm1;
      if (k == 3) x = P_TB;
      op(x, y, int'($urandom_range(0, 3)));
    end

    repeat (5) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL leftover got=%0d pending want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
